// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-port arbiter and access sequencer in front of a single-port data memory
// (combinational read, write committed on the rising clock edge). Port 0 is the
// CPU load/store unit, port 1 the debug/DMA loader. One access is in flight at
// a time; each takes three cycles (IDLE -> ACCESS -> RESP). Ties are broken
// round-robin against the last granted port.
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   req0/1, we0/1           request (held until ack) and write select
//   addr0/1, wdata0/1       byte address and write data per requester
//   ack0/1                  one-cycle completion pulse
//   rdata0/1                registered read data, held after the ack
//   mem_address             memory address (latched request address)
//   mem_write_data          memory write data (latched request data)
//   mem_memwrite            memory write enable, high only in ACCESS of a write
//   mem_read_data           combinational memory read data
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_memwrite,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic                  grant_en;
  logic                  grant_sel;
  logic                  last_grant;
  logic                  winner;
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;

  // Next-state and arbitration. Requests are only looked at in IDLE, so a
  // request raised during ACCESS/RESP simply waits for the next IDLE cycle.
  always_comb begin
    state_next = state;
    grant_en   = 1'b0;
    grant_sel  = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant_en   = 1'b1;
          state_next = ACCESS;
          // On a tie the port that did not win last time goes next.
          if (req0 && req1) grant_sel = ~last_grant;
          else              grant_sel = req1;
        end
      end
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Request capture. last_grant resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      winner     <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else if (grant_en) begin
      last_grant <= grant_sel;
      winner     <= grant_sel;
      lat_we     <= grant_sel ? we1    : we0;
      lat_addr   <= grant_sel ? addr1  : addr0;
      lat_wdata  <= grant_sel ? wdata1 : wdata0;
    end
  end

  // Response: the closing edge of ACCESS captures the memory's pre-write read
  // data for the winner and raises its ack for the single RESP cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      ack0 <= (state == ACCESS) && !winner;
      ack1 <= (state == ACCESS) &&  winner;
      if (state == ACCESS) begin
        if (winner) rdata1 <= mem_read_data;
        else        rdata0 <= mem_read_data;
      end
    end
  end

  // Write enable decoded only from registers; the asynchronous reset forces
  // state to IDLE, which removes the enable before the next edge.
  assign mem_memwrite   = (state == ACCESS) && lat_we;
  assign mem_address    = lat_addr;
  assign mem_write_data = lat_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: a 32-word memory hangs off the memory port, a
// transaction-level reference model predicts every ack (cycle and read data),
// and a monitor process compares the DUT against those predictions.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_memwrite;

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_memwrite(mem_memwrite), .mem_read_data(mem_read_data)
  );

  always #5 clock = ~clock;

  // Data memory: combinational read, write on the rising edge.
  logic [31:0] mem [32] = '{default: 32'h0};
  assign mem_read_data = mem[mem_address[6:2]];
  always @(posedge clock) if (mem_memwrite) mem[mem_address[6:2]] <= mem_write_data;

  int tests  = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string detail);
    tests++;
    errors++;
    $display("FAIL %s: %s", name, detail);
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] rdata; int ack_edge; } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  logic [31:0] refmem [32] = '{default: 32'h0};
  int          edge_n = 0;
  int          free_edge = 0;
  logic        last = 1'b1;
  logic        pend_valid = 1'b0;
  logic        pend_we = 1'b0;
  int          pend_edge = 0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] pend_wdata = 32'h0;

  // Every access occupies a 3-edge slot: granted at edge E, memory touched at
  // E+1 (the write lands there), ack visible after E+1, next grant at E+3.
  initial begin
    forever begin
      @(posedge clock);
      edge_n++;
      if (reset) begin
        q0.delete();
        q1.delete();
        pend_valid = 1'b0;
        last       = 1'b1;
        free_edge  = 0;
      end else begin
        if (pend_valid && edge_n == pend_edge) begin
          if (pend_we) refmem[pend_addr[6:2]] = pend_wdata;
          pend_valid = 1'b0;
        end
        if (edge_n >= free_edge && (req0 || req1)) begin
          logic w;
          exp_t e;
          w = (req0 && req1) ? !last : req1;
          pend_we    = w ? we1 : we0;
          pend_addr  = w ? addr1 : addr0;
          pend_wdata = w ? wdata1 : wdata0;
          pend_edge  = edge_n + 1;
          pend_valid = 1'b1;
          e.rdata    = refmem[pend_addr[6:2]];
          e.ack_edge = edge_n + 1;
          if (w) q1.push_back(e);
          else   q0.push_back(e);
          last      = w;
          free_edge = edge_n + 3;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic [31:0] hold0 = 32'h0;
  logic [31:0] hold1 = 32'h0;

  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        hold0 = 32'h0;
        hold1 = 32'h0;
      end else begin
        logic in_access;
        exp_t e;
        check("ack_exclusive", {63'h0, ack0 & ack1}, 64'h0);
        in_access = pend_valid && (edge_n == pend_edge - 1);
        check("memwrite", {63'h0, mem_memwrite}, {63'h0, in_access && pend_we});
        if (in_access) check("mem_address", {32'h0, mem_address}, {32'h0, pend_addr});
        if (ack0) begin
          if (q0.size() == 0) fail("ack0_unexpected", "ack0=1, expected 0");
          else begin
            e = q0.pop_front();
            check("rdata0", {32'h0, rdata0}, {32'h0, e.rdata});
            check("ack0_cycle", 64'(edge_n), 64'(e.ack_edge));
            hold0 = e.rdata;
          end
        end else begin
          check("rdata0_hold", {32'h0, rdata0}, {32'h0, hold0});
          if (q0.size() > 0 && q0[0].ack_edge < edge_n) begin
            fail("ack0_missing", $sformatf("ack0=0 at edge %0d, expected 1 at edge %0d", edge_n, q0[0].ack_edge));
            void'(q0.pop_front());
          end
        end
        if (ack1) begin
          if (q1.size() == 0) fail("ack1_unexpected", "ack1=1, expected 0");
          else begin
            e = q1.pop_front();
            check("rdata1", {32'h0, rdata1}, {32'h0, e.rdata});
            check("ack1_cycle", 64'(edge_n), 64'(e.ack_edge));
            hold1 = e.rdata;
          end
        end else begin
          check("rdata1_hold", {32'h0, rdata1}, {32'h0, hold1});
          if (q1.size() > 0 && q1[0].ack_edge < edge_n) begin
            fail("ack1_missing", $sformatf("ack1=0 at edge %0d, expected 1 at edge %0d", edge_n, q1[0].ack_edge));
            void'(q1.pop_front());
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; int gap; } txn_t;
  txn_t l0[$];
  txn_t l1[$];
  logic active0, active1, loaded0, loaded1;
  int   cnt0, cnt1;

  // Requesters: each waits `gap` cycles, raises req, holds it until its ack is
  // seen, then drops it (RESP ignores requests, so dropping during the ack
  // cycle is equivalent to dropping on the edge that ends it).
  task automatic drive();
    int   guard = 0;
    int   tail  = 0;
    txn_t t;
    active0 = 1'b0; active1 = 1'b0; loaded0 = 1'b0; loaded1 = 1'b0;
    while (tail < 4) begin
      @(negedge clock);
      guard++;
      if (guard > 3000) begin
        fail("drive_timeout", "requests still outstanding after 3000 cycles, expected completion");
        l0.delete(); l1.delete();
        req0 = 1'b0; req1 = 1'b0; active0 = 1'b0; active1 = 1'b0;
        tail = 4;
      end else begin
        if (active0) begin
          if (ack0) begin req0 = 1'b0; active0 = 1'b0; end
        end else if (l0.size() > 0) begin
          if (!loaded0) begin cnt0 = l0[0].gap; loaded0 = 1'b1; end
          if (cnt0 == 0) begin
            t = l0.pop_front();
            req0 = 1'b1; we0 = t.we; addr0 = t.addr; wdata0 = t.wdata;
            active0 = 1'b1; loaded0 = 1'b0;
          end else cnt0--;
        end
        if (active1) begin
          if (ack1) begin req1 = 1'b0; active1 = 1'b0; end
        end else if (l1.size() > 0) begin
          if (!loaded1) begin cnt1 = l1[0].gap; loaded1 = 1'b1; end
          if (cnt1 == 0) begin
            t = l1.pop_front();
            req1 = 1'b1; we1 = t.we; addr1 = t.addr; wdata1 = t.wdata;
            active1 = 1'b1; loaded1 = 1'b0;
          end else cnt1--;
        end
        if (l0.size() == 0 && l1.size() == 0 && !active0 && !active1) tail++;
        else tail = 0;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ack0"}, {63'h0, ack0}, 64'h0);
    check({tag, "_ack1"}, {63'h0, ack1}, 64'h0);
    check({tag, "_rdata0"}, {32'h0, rdata0}, 64'h0);
    check({tag, "_rdata1"}, {32'h0, rdata1}, 64'h0);
    check({tag, "_memwrite"}, {63'h0, mem_memwrite}, 64'h0);
    check({tag, "_address"}, {32'h0, mem_address}, 64'h0);
    check({tag, "_wdata"}, {32'h0, mem_write_data}, 64'h0);
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
    repeat (3) @(negedge clock);
    check_reset_values("reset");
    #2 reset = 1'b0;

    // Both ports reading from reset: port 0 first, then strict alternation.
    l0.push_back('{1'b0, 32'h40, 32'h0, 0});
    l0.push_back('{1'b0, 32'h44, 32'h0, 0});
    l1.push_back('{1'b0, 32'h48, 32'h0, 0});
    l1.push_back('{1'b0, 32'h4C, 32'h0, 0});
    drive();

    // Port 0 write then read of 0x10.
    l0.push_back('{1'b1, 32'h10, 32'hDEADBEEF, 0});
    l0.push_back('{1'b0, 32'h10, 32'h0, 1});
    drive();
    check("p0_readback", {32'h0, rdata0}, {32'h0, 32'hDEADBEEF});

    // Port 1 overwrite returns the old contents.
    l1.push_back('{1'b1, 32'h10, 32'h12345678, 0});
    drive();
    check("p1_read_before_write", {32'h0, rdata1}, {32'h0, 32'hDEADBEEF});

    // Reset asserted in the ACCESS cycle of a port 0 write.
    @(negedge clock);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'hCAFEF00D;
    @(negedge clock);
    #2 check("rst_pre_memwrite", {63'h0, mem_memwrite}, 64'h1);
    reset = 1'b1;
    #1 check_reset_values("rst_access");
    req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
    @(negedge clock);
    #2 reset = 1'b0;
    l0.push_back('{1'b0, 32'h10, 32'h0, 0});
    l0.push_back('{1'b0, 32'h20, 32'h0, 0});
    drive();
    check("rst_write_dropped", {32'h0, rdata0}, 64'h0);

    // req1 raised during port 0's ACCESS cycle waits for the next IDLE.
    l0.push_back('{1'b0, 32'h10, 32'h0, 0});
    l1.push_back('{1'b0, 32'h40, 32'h0, 1});
    drive();

    // Randomised traffic on both ports.
    for (int i = 0; i < 60; i++) begin
      l0.push_back('{1'($urandom_range(0, 1)), $urandom, $urandom, int'($urandom_range(0, 3))});
      l1.push_back('{1'($urandom_range(0, 1)), $urandom, $urandom, int'($urandom_range(0, 3))});
    end
    drive();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the single-port data memory. Shares one memory (combinational read, write on the rising clock edge when `memwrite` is high) between two requesters. Port 0 is the CPU load/store unit and port 1 is the debug/DMA loader. Grants one access at a time with round-robin fairness, drives the memory's address, data and write-enable, and returns registered read data with a one-cycle acknowledge.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, width of the request address and the memory address.
- `DATA_WIDTH`, 32, width of the write data and the read data.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req0`, `req1`  in  1  access request; held high until the matching ack is seen.
- `we0`, `we1`  in  1  1 = write, 0 = read; sampled with the request.
- `addr0`, `addr1`  in  ADDR_WIDTH  byte address; the memory uses bits [6:2].
- `wdata0`, `wdata1`  in  DATA_WIDTH  write data.
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `rdata0`, `rdata1`  out  DATA_WIDTH  registered read data, valid while the matching ack is high, held afterwards.
- `mem_address`  out  ADDR_WIDTH  to memory `address`.
- `mem_write_data`  out  DATA_WIDTH  to memory `write_data`.
- `mem_memwrite`  out  1  to memory `memwrite`.
- `mem_read_data`  in  DATA_WIDTH  from memory `read_data`.

## Operation
- State machine: IDLE -> ACCESS -> RESP -> IDLE.
- **IDLE**
  - No request: stay in IDLE.
  - Any request: pick a winner, latch its `we`/`addr`/`wdata` into internal registers, record the winner, go to ACCESS.
- **Arbitration** (decided in IDLE only)
  - Only one request: that port wins.
  - Both requests: the port not in `last_grant` wins.
  - `last_grant` updates on every grant.
- **ACCESS**
  - `mem_address` and `mem_write_data` come from the latched registers.
  - `mem_memwrite` = latched `we`.
  - On the closing edge:
    - the memory performs the write, if any;
    - `mem_read_data` is captured into the winner's `rdata`;
    - the winner's ack is set;
    - go to RESP.
- **RESP**
  - Winner's ack is high for exactly this cycle.
  - Requests are ignored.
  - Go to IDLE.
- **Requester contract:** drop `req` on the edge that ends the ack cycle. A `req` still high in IDLE is treated as a new request.
- **Write transactions:** the captured `rdata` is the contents before the write, because the read is combinational and the write commits on the same edge.
- **Outputs outside ACCESS:**
  - `mem_memwrite` is 0.
  - `mem_address`/`mem_write_data` show the latched values.
  - The non-winning port's `rdata` is unchanged.
- **Address handling:** passed through unchanged. Misaligned addresses are not flagged; the low bits are ignored by the memory.

## Timing
- Reset values (asynchronous):
  - state IDLE; `last_grant` = 1, so port 0 wins the first tie;
  - `ack0` = `ack1` = 0; `rdata0` = `rdata1` = 0;
  - latched we/addr/wdata = 0, so `mem_memwrite` = 0 and `mem_address` = 0.
- Latency: request sampled at edge E; ACCESS in cycle E+1; ack high in cycle E+2; IDLE in cycle E+3.
- Throughput: one access per 3 cycles.
- Both ports requesting continuously are served alternately: 0, 1, 0, 1, …
- A request arriving during ACCESS or RESP waits; it is evaluated in the next IDLE.
- `mem_memwrite` is high only during ACCESS of a write, and only from registered state (glitch-free).
- Reset asserted during ACCESS:
  - `mem_memwrite` drops immediately, so the write is not committed at the following edge if reset is still high;
  - no ack is issued;
  - the requester must re-issue.
- Reset during RESP clears the ack immediately.
- `ack0` and `ack1` are never high in the same cycle.

## Test plan
- **Reset:** assert reset mid-simulation -> all outputs match the reset values listed in Timing; `mem_memwrite` = 0 within the reset cycle, no clock edge needed.
- **Port 0 write then read:**
  - write `addr0` = 0x10, `wdata0` = 0xDEADBEEF -> `mem_memwrite` high for exactly one cycle, `ack0` two cycles after the request edge;
  - then read 0x10 -> `rdata0` = 0xDEADBEEF with `ack0`.
- **Read-before-write on a write transaction:** port 1 writes 0x12345678 to 0x10, which already holds 0xDEADBEEF -> `rdata1` = 0xDEADBEEF.
- **Simultaneous requests after reset:** both ports read -> port 0 acked first, port 1 acked 3 cycles later. Holding both requests for 4 transactions -> ack order 0, 1, 0, 1.
- **Reset during ACCESS:** port 0 write of 0xCAFEF00D to 0x20, reset asserted in the ACCESS cycle -> no ack; a later read of 0x20 returns 0.
- **Late request:** `req1` raised during port 0's ACCESS cycle -> port 1's ACCESS starts in the first cycle after IDLE; `ack1` exactly 3 cycles after `ack0`.
